// File: rtl/line_buffer_arb_pkg.sv
// Shared types and defaults for the refill line buffer arbiter.
// Request structs, data width and grant encoding used by line_buffer_arb and lb_starve_prio.
package line_buffer_arb_pkg;

    localparam int dataBits             = 8;
    localparam int ID_BITS              = 2;
    localparam int OFF_BITS             = 2;
    localparam int ADDR_BITS            = ID_BITS + OFF_BITS;
    localparam int N_IDS_DEFAULT        = 4;
    localparam int N_BEATS_DEFAULT      = 4;
    localparam int STARVE_LIMIT_DEFAULT = 3;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WR   = 2'd1,
        GRANT_RD   = 2'd2
    } grant_e;

    typedef struct packed {
        logic [ID_BITS-1:0]  id;
        logic [OFF_BITS-1:0] offset;
        logic [dataBits-1:0] data;
    } LineBufferWriteReqST;

    typedef struct packed {
        logic [ID_BITS-1:0]  id;
        logic [OFF_BITS-1:0] offset;
    } LineBufferReadReqST;

    // SRAM word address of one beat: entry id in the upper bits, beat offset below.
    function automatic logic [ADDR_BITS-1:0] beat_addr(input logic [ID_BITS-1:0]  id,
                                                        input logic [OFF_BITS-1:0] offset);
        return {id, offset};
    endfunction

endpackage

// File: rtl/line_buffer_arb_starve_prio.sv
// Write-over-read priority with a 2-bit saturating starvation counter.
// A read denied STARVE_LIMIT times in a row takes the SRAM port from the writer.
import line_buffer_arb_pkg::*;

module lb_starve_prio #(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   wr_valid,
    input  logic   rd_eligible,
    input  logic   rd_bypass,
    output logic   wr_ready,
    output logic   rd_ready,
    output grant_e grant
);

    localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

    logic [1:0] starve_q;
    logic [1:0] starve_d;
    logic       rd_wins;

    always_comb begin
        rd_wins  = rd_eligible && (!wr_valid || (starve_q >= LIMIT));
        wr_ready = !rd_wins;
        rd_ready = rd_wins;
        if (rd_wins) begin
            grant = GRANT_RD;
        end else if (wr_valid) begin
            grant = GRANT_WR;
        end else begin
            grant = GRANT_NONE;
        end
    end

    // A bypassed read is served alongside the write, so it counts as granted.
    always_comb begin
        starve_d = 2'd0;
        if (rd_eligible && !rd_wins && !rd_bypass) begin
            starve_d = (starve_q == 2'b11) ? 2'b11 : starve_q + 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= 2'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/line_buffer_arb.sv
// Line buffer arbiter: per-beat valid bitmap, single-port SRAM muxing and read response register.
// Optional same-cycle write-to-read forwarding is enabled with LINE_BUFFER_BYPASS_EN.
import line_buffer_arb_pkg::*;

module line_buffer_arb #(
    parameter int N_IDS        = N_IDS_DEFAULT,
    parameter int N_BEATS      = N_BEATS_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  LineBufferWriteReqST        wr_req,
    input  logic                       rd_valid,
    output logic                       rd_ready,
    input  LineBufferReadReqST         rd_req,
    input  logic                       clr_valid,
    input  logic [ID_BITS-1:0]         clr_id,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_BITS-1:0]       mem_addr,
    output logic [dataBits-1:0]        mem_wdata,
    input  logic [dataBits-1:0]        mem_rdata,
    output logic                       resp_valid,
    output logic [dataBits-1:0]        resp_data,
    output logic [N_IDS*N_BEATS-1:0]   beat_valid
);

    localparam int N_ENTRIES = N_IDS * N_BEATS;

    logic [N_ENTRIES-1:0] beat_valid_q;
    logic [N_ENTRIES-1:0] beat_valid_d;
    logic                 resp_valid_q;
    logic                 resp_valid_d;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_eligible;
    logic                 rd_bypass;
    logic                 wr_ready_arb;
    logic                 rd_ready_arb;
    grant_e               grant;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 rd_sram_fire;

`ifdef LINE_BUFFER_BYPASS_EN
    logic                 resp_byp_q;
    logic                 resp_byp_d;
    logic [dataBits-1:0]  resp_byp_data_q;
    logic [dataBits-1:0]  resp_byp_data_d;
`endif

    lb_starve_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_prio (
        .clock       (clock),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .rd_eligible (rd_eligible),
        .rd_bypass   (rd_bypass),
        .wr_ready    (wr_ready_arb),
        .rd_ready    (rd_ready_arb),
        .grant       (grant)
    );

    // A clear to the read's entry this cycle makes its beat stale, so it may not compete.
    always_comb begin
        wr_addr     = beat_addr(wr_req.id, wr_req.offset);
        rd_addr     = beat_addr(rd_req.id, rd_req.offset);
        rd_eligible = rd_valid && beat_valid_q[rd_addr] && !(clr_valid && (clr_id == rd_req.id));
`ifdef LINE_BUFFER_BYPASS_EN
        rd_bypass   = rd_valid && (grant == GRANT_WR) && (rd_addr == wr_addr);
`else
        rd_bypass   = 1'b0;
`endif
    end

    always_comb begin
        wr_fire      = !reset && (grant == GRANT_WR);
        rd_sram_fire = !reset && (grant == GRANT_RD);
        rd_fire      = rd_sram_fire || (!reset && rd_bypass);
        wr_ready     = wr_ready_arb;
        rd_ready     = !reset && (rd_ready_arb || rd_bypass);
        mem_en       = wr_fire || rd_sram_fire;
        mem_we       = wr_fire;
        mem_addr     = wr_fire ? wr_addr : rd_addr;
        mem_wdata    = wr_req.data;
        resp_valid   = resp_valid_q;
        beat_valid   = beat_valid_q;
`ifdef LINE_BUFFER_BYPASS_EN
        resp_data    = resp_byp_q ? resp_byp_data_q : mem_rdata;
`else
        resp_data    = mem_rdata;
`endif
    end

    // Clear first, then the write, so a refill beat landing with its own clear survives.
    always_comb begin
        beat_valid_d = beat_valid_q;
        if (clr_valid) begin
            for (int b = 0; b < N_BEATS; b++) begin
                beat_valid_d[{clr_id, b[OFF_BITS-1:0]}] = 1'b0;
            end
        end
        if (wr_fire) begin
            beat_valid_d[wr_addr] = 1'b1;
        end
        resp_valid_d = rd_fire;
`ifdef LINE_BUFFER_BYPASS_EN
        resp_byp_d      = rd_bypass;
        resp_byp_data_d = wr_req.data;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_valid_q    <= '0;
            resp_valid_q    <= 1'b0;
`ifdef LINE_BUFFER_BYPASS_EN
            resp_byp_q      <= 1'b0;
            resp_byp_data_q <= '0;
`endif
        end else begin
            beat_valid_q    <= beat_valid_d;
            resp_valid_q    <= resp_valid_d;
`ifdef LINE_BUFFER_BYPASS_EN
            resp_byp_q      <= resp_byp_d;
            resp_byp_data_q <= resp_byp_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_line_buffer_arb.sv
// Directed testbench for line_buffer_arb with a behavioural 1-cycle-latency SRAM.
// Build with LINE_BUFFER_BYPASS_EN defined to exercise write-to-read forwarding.
import line_buffer_arb_pkg::*;

module tb_line_buffer_arb;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  wr_valid;
    logic                  wr_ready;
    LineBufferWriteReqST   wr_req;
    logic                  rd_valid;
    logic                  rd_ready;
    LineBufferReadReqST    rd_req;
    logic                  clr_valid;
    logic [ID_BITS-1:0]    clr_id;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [dataBits-1:0]   mem_wdata;
    logic [dataBits-1:0]   mem_rdata;
    logic                  resp_valid;
    logic [dataBits-1:0]   resp_data;
    logic [15:0]           beat_valid;

    logic [dataBits-1:0]   sram [16];
    int                    compared   = 0;
    int                    mismatched = 0;

    line_buffer_arb dut (
        .clock      (clock),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_req     (wr_req),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_req     (rd_req),
        .clr_valid  (clr_valid),
        .clr_id     (clr_id),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .beat_valid (beat_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_en && mem_we) begin
            sram[mem_addr] <= mem_wdata;
        end else if (mem_en) begin
            mem_rdata <= sram[mem_addr];
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [1:0] wid, input logic [1:0] woff,
                                 input logic [7:0] wdat, input logic rv, input logic [1:0] rid,
                                 input logic [1:0] roff, input logic cv, input logic [1:0] cid);
        wr_valid      = wv;
        wr_req.id     = wid;
        wr_req.offset = woff;
        wr_req.data   = wdat;
        rd_valid      = rv;
        rd_req.id     = rid;
        rd_req.offset = roff;
        clr_valid     = cv;
        clr_id        = cid;
        #1;
    endtask

    initial begin
        mem_rdata = '0;
        reset     = 1'b1;
        applyStimulus(1'b1, 2'd0, 2'd1, 8'h99, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
        checkOutput("reset_beat_valid", 32'(beat_valid), 32'h0);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("reset_mem_en", 32'(mem_en), 32'h0);
        checkOutput("reset_wr_ready", 32'(wr_ready), 32'h1);
        checkOutput("reset_rd_ready", 32'(rd_ready), 32'h0);
        step();
        step();
        reset = 1'b0;

        // Write then read back id=1 off=2
        applyStimulus(1'b1, 2'd1, 2'd2, 8'hA5, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
        checkOutput("wr_ready_idle", 32'(wr_ready), 32'h1);
        checkOutput("wr_mem_en", 32'(mem_en), 32'h1);
        checkOutput("wr_mem_we", 32'(mem_we), 32'h1);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'h6);
        checkOutput("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2, 1'b0, 2'd0);
        checkOutput("beat6_set", 32'(beat_valid), 32'h0040);
        checkOutput("rd_ready_hit", 32'(rd_ready), 32'h1);
        checkOutput("rd_mem_en", 32'(mem_en), 32'h1);
        checkOutput("rd_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rd_mem_addr", 32'(mem_addr), 32'h6);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
        checkOutput("rd_resp_valid", 32'(resp_valid), 32'h1);
        checkOutput("rd_resp_data", 32'(resp_data), 32'hA5);
        step();
        checkOutput("resp_valid_drop", 32'(resp_valid), 32'h0);

        // Read of an unwritten beat waits for its refill
        applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0);
        checkOutput("miss_rd_ready0", 32'(rd_ready), 32'h0);
        checkOutput("miss_mem_en0", 32'(mem_en), 32'h0);
        step();
        checkOutput("miss_rd_ready1", 32'(rd_ready), 32'h0);
        checkOutput("miss_mem_en1", 32'(mem_en), 32'h0);
        applyStimulus(1'b1, 2'd0, 2'd0, 8'h3C, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0);
        checkOutput("miss_wr_ready", 32'(wr_ready), 32'h1);
        checkOutput("miss_rd_ready_wr", 32'(rd_ready), 32'h0);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0);
        checkOutput("miss_rd_granted", 32'(rd_ready), 32'h1);
        checkOutput("miss_rd_mem_en", 32'(mem_en), 32'h1);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
        checkOutput("miss_resp_valid", 32'(resp_valid), 32'h1);
        checkOutput("miss_resp_data", 32'(resp_data), 32'h3C);

        // Starvation: continuous writes, read wins on the 4th cycle
        applyStimulus(1'b1, 2'd2, 2'd0, 8'h11, 1'b1, 2'd1, 2'd2, 1'b0, 2'd0);
        for (int i = 1; i <= 3; i++) begin
            checkOutput($sformatf("starve_wr_ready_c%0d", i), 32'(wr_ready), 32'h1);
            checkOutput($sformatf("starve_rd_ready_c%0d", i), 32'(rd_ready), 32'h0);
            step();
        end
        checkOutput("starve_wr_ready_c4", 32'(wr_ready), 32'h0);
        checkOutput("starve_rd_ready_c4", 32'(rd_ready), 32'h1);
        checkOutput("starve_mem_we_c4", 32'(mem_we), 32'h0);
        checkOutput("starve_mem_addr_c4", 32'(mem_addr), 32'h6);
        step();
        checkOutput("starve_wr_ready_c5", 32'(wr_ready), 32'h1);
        checkOutput("starve_rd_ready_c5", 32'(rd_ready), 32'h0);
        checkOutput("starve_resp_valid", 32'(resp_valid), 32'h1);
        checkOutput("starve_resp_data", 32'(resp_data), 32'hA5);
        step();

        // Clear of id=2 with same-cycle write id=2 off=1
        applyStimulus(1'b1, 2'd2, 2'd1, 8'h77, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2);
        step();
        checkOutput("clr_wr_id2", 32'(beat_valid[11:8]), 32'h2);
        checkOutput("clr_other_ids", 32'(beat_valid), 32'h0241);

        // A clear to the read's id blocks that read
        applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2, 1'b1, 2'd1);
        checkOutput("clr_blocks_rd_ready", 32'(rd_ready), 32'h0);
        checkOutput("clr_blocks_mem_en", 32'(mem_en), 32'h0);
        step();
        checkOutput("clr_id1_beats", 32'(beat_valid[7:4]), 32'h0);

        // Reset right after a read grant kills the pending response
        applyStimulus(1'b1, 2'd3, 2'd0, 8'h42, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd0, 1'b0, 2'd0);
        checkOutput("prerst_rd_ready", 32'(rd_ready), 32'h1);
        step();
        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("rst_beat_valid", 32'(beat_valid), 32'h0);
        checkOutput("rst_mem_en", 32'(mem_en), 32'h0);
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'h1);
        step();
        checkOutput("rst_resp_valid_hold", 32'(resp_valid), 32'h0);
        reset = 1'b0;
        step();

        // Same-cycle write and read of id=3 off=3
        applyStimulus(1'b1, 2'd3, 2'd3, 8'h5A, 1'b1, 2'd3, 2'd3, 1'b0, 2'd0);
        checkOutput("same_wr_ready", 32'(wr_ready), 32'h1);
        checkOutput("same_mem_we", 32'(mem_we), 32'h1);
`ifdef LINE_BUFFER_BYPASS_EN
        checkOutput("byp_rd_ready", 32'(rd_ready), 32'h1);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
        checkOutput("byp_resp_valid", 32'(resp_valid), 32'h1);
        checkOutput("byp_resp_data", 32'(resp_data), 32'h5A);
`else
        checkOutput("nobyp_rd_ready", 32'(rd_ready), 32'h0);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 1'b0, 2'd0);
        checkOutput("nobyp_resp_valid0", 32'(resp_valid), 32'h0);
        checkOutput("nobyp_rd_ready_late", 32'(rd_ready), 32'h1);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
        checkOutput("nobyp_resp_valid", 32'(resp_valid), 32'h1);
        checkOutput("nobyp_resp_data", 32'(resp_data), 32'h5A);
`endif
        step();
        checkOutput("final_resp_idle", 32'(resp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
